// File: rtl/power_domain_scheduler.sv
// Vote-driven power sequencer in front of power_gating_controller: on/off request handshake, idle hysteresis, ack watchdog.
// Optional PWR_SCHED_STATS_EN adds saturating on_count / timeout_count outputs.
module power_domain_scheduler #(
  parameter int N_REQ       = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] vote,
  input  logic             force_off,
  input  logic             clear_err,
  input  logic             power_on_ack,
  input  logic             power_off_ack,
  output logic             power_on_req,
  output logic             power_off_req,
  output logic             domain_ready,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state
`ifdef PWR_SCHED_STATS_EN
  ,
  output logic [15:0]      on_count,
  output logic [7:0]       timeout_count
`endif
);

  localparam int CNT_MAX = (IDLE_CYCLES > ACK_TIMEOUT) ? IDLE_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'((IDLE_CYCLES >= 2) ? IDLE_CYCLES - 2 : 0);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic          IDLE_ONE  = (IDLE_CYCLES == 1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_ON_REQ    = 3'd1,
    S_ON        = 3'd2,
    S_IDLE_WAIT = 3'd3,
    S_OFF_REQ   = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  state_t        cur;
  logic [CW-1:0] cnt;
  logic          any_vote;
  logic          on_done;
  logic          off_done;
  logic          timeout;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  assign any_vote = (|vote) & ~force_off;
  assign on_done  = (cur == S_ON_REQ)  && power_on_ack;
  assign off_done = (cur == S_OFF_REQ) && power_off_ack;
  // An ack landing on the timeout cycle wins over the watchdog.
  assign timeout  = (cnt == ACK_LAST) &&
                    (((cur == S_ON_REQ) && !power_on_ack) || ((cur == S_OFF_REQ) && !power_off_ack));
  assign state    = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur           <= S_OFF;
      cnt           <= '0;
      power_on_req  <= 1'b0;
      power_off_req <= 1'b0;
      domain_ready  <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (cur)
        S_OFF: begin
          if (any_vote) begin
            cur          <= S_ON_REQ;
            cnt          <= '0;
            power_on_req <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_ON_REQ: begin
          if (on_done) begin
            cur          <= S_ON;
            cnt          <= '0;
            power_on_req <= 1'b0;
            busy         <= 1'b0;
            domain_ready <= 1'b1;
          end else if (timeout) begin
            cur          <= S_ERR;
            power_on_req <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_ON: begin
          if (force_off || (!any_vote && IDLE_ONE)) begin
            cur           <= S_OFF_REQ;
            cnt           <= '0;
            power_off_req <= 1'b1;
            busy          <= 1'b1;
            domain_ready  <= 1'b0;
          end else if (!any_vote) begin
            cur <= S_IDLE_WAIT;
            cnt <= '0;
          end
        end
        // cnt trails the idle-cycle count by one: the ON->IDLE_WAIT edge is the first idle cycle.
        S_IDLE_WAIT: begin
          if (force_off || (!any_vote && cnt == IDLE_LAST)) begin
            cur           <= S_OFF_REQ;
            cnt           <= '0;
            power_off_req <= 1'b1;
            busy          <= 1'b1;
            domain_ready  <= 1'b0;
          end else if (any_vote) begin
            cur <= S_ON;
            cnt <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_OFF_REQ: begin
          if (off_done) begin
            cur           <= S_OFF;
            cnt           <= '0;
            power_off_req <= 1'b0;
            busy          <= 1'b0;
          end else if (timeout) begin
            cur           <= S_ERR;
            power_off_req <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_ERR: begin
          if (clear_err) begin
            cur <= S_OFF;
            cnt <= '0;
            err <= 1'b0;
          end
        end
        default: begin
          cur           <= S_OFF;
          cnt           <= '0;
          power_on_req  <= 1'b0;
          power_off_req <= 1'b0;
          domain_ready  <= 1'b0;
          busy          <= 1'b0;
          err           <= 1'b0;
        end
      endcase
    end
  end

`ifdef PWR_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_count      <= '0;
      timeout_count <= '0;
    end else begin
      if (on_done) on_count <= sat_inc16(on_count);
      if (timeout) timeout_count <= sat_inc8(timeout_count);
    end
  end
`endif

endmodule
